apb_master: RTL and testbench

APB initiator that converts a simple valid/ready request/response interface into APB setup/access transfers toward peripherals such as the UART register block. It sits between an internal bus agent (core load/store unit or debug path) and the peripheral APB fabric, issuing one transfer at a time. For each transfer it returns read data, the slave error flag, and a wait-state timeout indication.

---
 rtl/apb_master.sv | 150 +++++++++++++++
 tb/tb_apb_master.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// apb_master: APB initiator bridging a valid/ready request/response
// interface onto APB setup/access transfers, one transfer at a time.
//
// Ports
//   pclk_i, prst_i        clock, synchronous active-high reset
//   req_valid_i/ready_o   request handshake
//   req_write_i           1 = write, 0 = read
//   req_addr_i/wdata_i    request address and write data
//   rsp_valid_o/ready_i   response handshake
//   rsp_rdata_o           read data (0 for writes, errors, timeouts)
//   rsp_err_o             slave error or timeout
//   rsp_timeout_o         transfer aborted after TIMEOUT wait cycles
//   paddr_o, pwdata_o, pwrite_o, psel_o, penable_o   APB request side
//   prdata_i, pready_i, pslverr_i                    APB completion side
//
// State  | meaning
// IDLE   | ready for a request
// SETUP  | APB setup phase (psel=1, penable=0), one cycle
// ACCESS | APB access phase, waiting for pready or timeout
// RESP   | response presented until rsp_ready_i
module apb_master #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              pclk_i,
  input  logic              prst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  output logic              pwrite_o,
  output logic              psel_o,
  output logic              penable_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i
);

  localparam int CNT_W = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                tmo_q, tmo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i && ready_q) begin
          write_d = req_write_i;
          addr_d  = req_addr_i;
          wdata_d = req_write_i ? req_wdata_i : '0;
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // pready has priority over a timeout hitting in the same cycle.
        if (pready_i) begin
          rdata_d = (!write_q && !pslverr_i) ? prdata_i : '0;
          err_d   = pslverr_i;
          tmo_d   = 1'b0;
          state_d = RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Ready is registered so it stays low while reset is applied and
    // only opens once the state register is known to be IDLE.
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready_o   = ready_q;
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = err_q;
  assign rsp_timeout_o = tmo_q;
  assign paddr_o       = addr_q;
  assign pwdata_o      = wdata_q;
  assign pwrite_o      = write_q;
  assign psel_o        = (state_q == SETUP) || (state_q == ACCESS);
  assign penable_o     = (state_q == ACCESS);

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed vector bench for apb_master (TIMEOUT=8).
module tb_apb_master;

  logic        pclk = 1'b0;
  logic        prst;
  logic        req_valid, req_ready, req_write;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite, psel, penable;
  logic [31:0] prdata;
  logic        pready, pslverr;

  int    n_checks = 0;
  int    n_errors = 0;
  string tag = "reset";

  always #5 pclk = ~pclk;

  apb_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(8)) dut (
    .pclk_i(pclk), .prst_i(prst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
    .paddr_o(paddr), .pwdata_o(pwdata), .pwrite_o(pwrite),
    .psel_o(psel), .penable_o(penable),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_tmo;
    int          exp_acc;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s/%s: got 0x%08h expected 0x%08h", tag, name, act, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [11:0] addr, input logic [31:0] wdata);
    @(negedge pclk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    @(negedge pclk);
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    chk("setup_psel", 32'(psel), 32'd1);
    chk("setup_penable", 32'(penable), 32'd0);
    chk("setup_paddr", 32'(paddr), 32'(addr));
    chk("setup_pwrite", 32'(pwrite), 32'(wr));
    chk("setup_pwdata", pwdata, wr ? wdata : 32'h0);
    chk("setup_req_ready", 32'(req_ready), 32'd0);
  endtask

  task automatic do_xfer(input vec_t v);
    int acc;
    issue(v.wr, v.addr, v.wdata);
    acc = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge pclk);
      if (!penable) break;
      acc++;
      chk("access_psel", 32'(psel), 32'd1);
      chk("access_paddr", 32'(paddr), 32'(v.addr));
      pready  = (acc == v.waits + 1);
      prdata  = v.prdata;
      pslverr = v.slverr;
    end
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    chk("access_count", 32'(acc), 32'(v.exp_acc));
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_psel_low", 32'(psel), 32'd0);
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(v.exp_tmo));
    chk("rsp_req_ready", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t wv;
    //             wr    addr     wdata         waits prdata        err   exp_rdata     err   tmo  acc
    vecs[0] = '{1'b1, 12'h00C, 32'hDEADBEEF, 0,  32'hAAAAAAAA, 1'b0, 32'h00000000, 1'b0, 1'b0, 1};
    vecs[1] = '{1'b0, 12'h010, 32'hFFFFFFFF, 3,  32'h12345678, 1'b0, 32'h12345678, 1'b0, 1'b0, 4};
    vecs[2] = '{1'b0, 12'h020, 32'h0,        0,  32'hCAFEF00D, 1'b1, 32'h00000000, 1'b1, 1'b0, 1};
    vecs[3] = '{1'b0, 12'h030, 32'h0,        99, 32'h87654321, 1'b0, 32'h00000000, 1'b1, 1'b1, 8};
    vecs[4] = '{1'b0, 12'h034, 32'h0,        7,  32'h55AA55AA, 1'b0, 32'h55AA55AA, 1'b0, 1'b0, 8};
    vecs[5] = '{1'b1, 12'hFFF, 32'h01234567, 2,  32'h0,        1'b1, 32'h00000000, 1'b1, 1'b0, 3};

    prst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;

    repeat (3) @(negedge pclk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_paddr", 32'(paddr), 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_timeout", 32'(rsp_timeout), 32'd0);
    prst = 1'b0;
    @(negedge pclk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 6; i++) begin
      tag = $sformatf("vec%0d", i);
      do_xfer(vecs[i]);
    end

    // Response backpressure with a new request waiting.
    tag = "backpressure";
    issue(1'b0, 12'h040, 32'h0);
    @(negedge pclk);
    chk("bp_access", 32'(penable), 32'd1);
    pready = 1'b1; prdata = 32'h0BADCAFE;
    @(negedge pclk);
    pready = 1'b0; prdata = '0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h044; req_wdata = 32'h11112222;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h0BADCAFE);
      chk("bp_rsp_err", 32'(rsp_err), 32'd0);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_psel", 32'(psel), 32'd0);
      @(negedge pclk);
    end
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    chk("bp_hs_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("bp_hs_req_ready", 32'(req_ready), 32'd1);
    chk("bp_hs_psel", 32'(psel), 32'd0);
    @(negedge pclk);
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    chk("bp2_setup_psel", 32'(psel), 32'd1);
    chk("bp2_setup_penable", 32'(penable), 32'd0);
    chk("bp2_paddr", 32'(paddr), 32'h044);
    chk("bp2_pwrite", 32'(pwrite), 32'd1);
    chk("bp2_pwdata", pwdata, 32'h11112222);
    @(negedge pclk);
    chk("bp2_access", 32'(penable), 32'd1);
    pready = 1'b1;
    @(negedge pclk);
    pready = 1'b0;
    chk("bp2_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("bp2_rsp_rdata", rsp_rdata, 32'h0);
    chk("bp2_rsp_err", 32'(rsp_err), 32'd0);
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;

    // Reset pulse in the middle of an ACCESS phase.
    tag = "reset_access";
    issue(1'b0, 12'h050, 32'h0);
    @(negedge pclk);
    chk("ra_access", 32'(penable), 32'd1);
    prst = 1'b1;
    @(negedge pclk);
    prst = 1'b0;
    chk("ra_psel", 32'(psel), 32'd0);
    chk("ra_penable", 32'(penable), 32'd0);
    chk("ra_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("ra_req_ready", 32'(req_ready), 32'd0);
    repeat (2) begin
      @(negedge pclk);
      chk("ra_no_rsp", 32'(rsp_valid), 32'd0);
      chk("ra_no_psel", 32'(psel), 32'd0);
    end
    tag = "after_reset_write";
    wv = '{1'b1, 12'h060, 32'hA5A55A5A, 1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 2};
    do_xfer(wv);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
